// File: rtl/atm_keypad_frontend.sv
// Customer-side ATM front end: card detect, PIN entry/compare, menu selection and amount entry.
// Optional inactivity abort is built when KEYPAD_TIMEOUT_EN is defined.
module atm_keypad_frontend #(
  parameter int unsigned MAX_AMOUNT = 9999
`ifdef KEYPAD_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        card_present,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] stored_pin,
  input  logic        exceed_balance,
  output logic        card_inserted,
  output logic        pin_entered,
  output logic        pin_correct,
  output logic [1:0]  transaction_choice,
  output logic [15:0] amount,
  output logic        key_error,
  output logic        timeout,
  output logic [2:0]  fe_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PIN    = 3'd1,
    S_MENU   = 3'd2,
    S_AMOUNT = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  localparam logic [3:0] KEY_ENTER    = 4'hA;
  localparam logic [3:0] KEY_CANCEL   = 4'hB;
  localparam logic [3:0] KEY_BALANCE  = 4'hC;
  localparam logic [3:0] KEY_WITHDRAW = 4'hD;

  localparam logic [1:0] CH_NONE     = 2'b00;
  localparam logic [1:0] CH_BALANCE  = 2'b01;
  localparam logic [1:0] CH_WITHDRAW = 2'b10;
  localparam logic [1:0] CH_CANCEL   = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] pin_buf_q, pin_buf_d;
  logic [2:0]  pin_cnt_q, pin_cnt_d;
  logic [15:0] acc_q, acc_d;
  logic        card_low_q, card_low_d;
  logic        card_inserted_q, card_inserted_d;
  logic        pin_entered_q, pin_entered_d;
  logic        pin_correct_q, pin_correct_d;
  logic [1:0]  choice_q, choice_d;
  logic [15:0] amount_q, amount_d;
  logic        key_error_q, key_error_d;
  logic        timeout_q, timeout_d;

  logic        is_digit;
  logic [19:0] acc_ext;
  logic        acc_ok;

  assign is_digit = (key_code <= 4'd9);
  assign acc_ext  = 20'(acc_q) * 20'd10 + 20'(key_code);
  assign acc_ok   = (acc_ext <= 20'(MAX_AMOUNT));

`ifdef KEYPAD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_active;
  assign tmo_active = (state_q == S_PIN) || (state_q == S_MENU) || (state_q == S_AMOUNT);
`endif

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      pin_buf_q       <= '0;
      pin_cnt_q       <= '0;
      acc_q           <= '0;
      card_low_q      <= 1'b0;
      card_inserted_q <= 1'b0;
      pin_entered_q   <= 1'b0;
      pin_correct_q   <= 1'b0;
      choice_q        <= CH_NONE;
      amount_q        <= '0;
      key_error_q     <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      pin_buf_q       <= pin_buf_d;
      pin_cnt_q       <= pin_cnt_d;
      acc_q           <= acc_d;
      card_low_q      <= card_low_d;
      card_inserted_q <= card_inserted_d;
      pin_entered_q   <= pin_entered_d;
      pin_correct_q   <= pin_correct_d;
      choice_q        <= choice_d;
      amount_q        <= amount_d;
      key_error_q     <= key_error_d;
      timeout_q       <= timeout_d;
    end
  end

`ifdef KEYPAD_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  // Next-state and output decode; card removal overrides everything else
  always_comb begin
    state_d         = state_q;
    pin_buf_d       = pin_buf_q;
    pin_cnt_d       = pin_cnt_q;
    acc_d           = acc_q;
    card_low_d      = ~card_present;
    card_inserted_d = 1'b0;
    pin_entered_d   = 1'b0;
    pin_correct_d   = pin_correct_q;
    choice_d        = choice_q;
    amount_d        = amount_q;
    key_error_d     = 1'b0;
    timeout_d       = 1'b0;

    if ((state_q != S_IDLE) && !card_present) begin
      state_d       = S_IDLE;
      pin_buf_d     = '0;
      pin_cnt_d     = '0;
      acc_d         = '0;
      pin_correct_d = 1'b0;
      choice_d      = CH_NONE;
      amount_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // card_low_q starts at 0 so a card present through reset is not re-detected
          if (card_present && card_low_q) begin
            card_inserted_d = 1'b1;
            pin_buf_d       = '0;
            pin_cnt_d       = '0;
            acc_d           = '0;
            state_d         = S_PIN;
          end
        end
        S_PIN: begin
          if (key_valid) begin
            if (is_digit) begin
              if (pin_cnt_q == 3'd4) begin
                key_error_d = 1'b1;
              end else begin
                pin_buf_d = {pin_buf_q[11:0], key_code};
                pin_cnt_d = pin_cnt_q + 3'd1;
              end
            end else if (key_code == KEY_ENTER) begin
              pin_buf_d = '0;
              pin_cnt_d = '0;
              if (pin_cnt_q == 3'd4) begin
                pin_entered_d = 1'b1;
                pin_correct_d = (pin_buf_q == stored_pin);
                if (pin_buf_q == stored_pin) state_d = S_MENU;
              end else begin
                key_error_d = 1'b1;
              end
            end else if (key_code == KEY_CANCEL) begin
              choice_d = CH_CANCEL;
              state_d  = S_HOLD;
            end
          end
        end
        S_MENU: begin
          if (key_valid) begin
            if (is_digit || (key_code == KEY_ENTER)) begin
              key_error_d = 1'b1;
            end else if (key_code == KEY_BALANCE) begin
              choice_d = CH_BALANCE;
              state_d  = S_HOLD;
            end else if (key_code == KEY_WITHDRAW) begin
              acc_d   = '0;
              state_d = S_AMOUNT;
            end else if (key_code == KEY_CANCEL) begin
              choice_d = CH_CANCEL;
              state_d  = S_HOLD;
            end
          end
        end
        S_AMOUNT: begin
          if (key_valid) begin
            if (is_digit) begin
              if (acc_ok) acc_d = acc_ext[15:0];
              else        key_error_d = 1'b1;
            end else if (key_code == KEY_ENTER) begin
              if (acc_q == '0) begin
                key_error_d = 1'b1;
              end else begin
                amount_d = acc_q;
                choice_d = CH_WITHDRAW;
                state_d  = S_HOLD;
              end
            end else if (key_code == KEY_CANCEL) begin
              choice_d = CH_CANCEL;
              state_d  = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (exceed_balance && (choice_q == CH_WITHDRAW)) begin
            choice_d = CH_NONE;
            acc_d    = '0;
            state_d  = S_AMOUNT;
          end
        end
        default: state_d = S_IDLE;
      endcase

`ifdef KEYPAD_TIMEOUT_EN
      if (tmo_active && !key_valid && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
        timeout_d = 1'b1;
        choice_d  = CH_CANCEL;
        state_d   = S_HOLD;
      end
`endif
    end
  end

`ifdef KEYPAD_TIMEOUT_EN
  // Inactivity counter restarts on any key or state change
  always_comb begin
    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    if (!tmo_active || key_valid || (state_d != state_q)) tmo_cnt_d = '0;
  end
`endif

  assign card_inserted      = card_inserted_q;
  assign pin_entered        = pin_entered_q;
  assign pin_correct        = pin_correct_q;
  assign transaction_choice = choice_q;
  assign amount             = amount_q;
  assign key_error          = key_error_q;
  assign timeout            = timeout_q;
  assign fe_state           = state_q;

endmodule
